// File: rtl/sobel_in_block_pkg.sv
// Shared types and constants for the SRAM pixel reader (fetch FSM states, row geometry, lane width).
package sobel_pkg;

    typedef enum logic [2:0] {
        F_IDLE,
        F_TOP,
        F_BOT,
        F_CAP,
        F_WAIT
    } fetchState_t;

    localparam int unsigned ROWSTRIDE = 256;
    localparam int unsigned ROWWORDS  = 256;
    localparam int unsigned LANE      = 8;

    // Beat k takes the 16-bit lane at bit 48-16k, which is lane index 3-k.
    function automatic logic [15:0] laneWord(input logic [63:0] w, input logic [1:0] k);
        return w[{~k, 4'b0000} +: 16];
    endfunction

endpackage

// File: rtl/sobel_in_block_if.sv
// Unpacked pixel stream from the SRAM reader to the Sobel/particle stages.
interface sobel_in_block_if;
    import sobel_pkg::*;

    logic [LANE-1:0] normalisedByte1;
    logic [LANE-1:0] normalisedByte2;
    logic [LANE-1:0] normalisedByte3;
    logic [LANE-1:0] normalisedByte4;
    logic            outValid;
    logic            outReady;

    modport master (
        output normalisedByte1,
        output normalisedByte2,
        output normalisedByte3,
        output normalisedByte4,
        output outValid,
        input  outReady
    );

    modport slave (
        input  normalisedByte1,
        input  normalisedByte2,
        input  normalisedByte3,
        input  normalisedByte4,
        input  outValid,
        output outReady
    );

endinterface

// File: rtl/sobel_in_block_sram_pair_fetch.sv
// Fetches top/bottom SRAM word pairs into a one-pair prefetch buffer.
module sram_pair_fetch #(
    parameter int unsigned STARTADDRESS = 0,
    parameter int unsigned ENDADDRESS   = 65536,
    parameter int unsigned ROWSTRIDE    = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frameStart,
    input  logic        nextTake,
    input  logic [63:0] inData,
    output logic        re,
    output logic [19:0] rdaddr,
    output logic        nextFull,
    output logic [63:0] nextTop,
    output logic [63:0] nextBot,
    output logic        fetchIdle
);
    import sobel_pkg::*;

    localparam logic [20:0] START21  = 21'(STARTADDRESS);
    localparam logic [19:0] START20  = 20'(STARTADDRESS);
    localparam logic [20:0] END21    = 21'(ENDADDRESS);
    localparam logic [20:0] STRIDE21 = 21'(ROWSTRIDE);
    localparam logic [19:0] STRIDE20 = 20'(ROWSTRIDE);

    fetchState_t state;
    logic [20:0] addr;
    logic [20:0] advAddr;
    logic [19:0] botAddr;

    // Past the last word of a top row, jump over the bottom row already read.
    assign advAddr = (addr[7:0] == 8'(ROWWORDS - 1)) ? addr + STRIDE21 + 21'd1 : addr + 21'd1;
    assign botAddr = addr[19:0] + STRIDE20;
    assign fetchIdle = (state == F_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= F_IDLE;
            addr     <= '0;
            re       <= 1'b0;
            rdaddr   <= '0;
            nextFull <= 1'b0;
            nextTop  <= '0;
            nextBot  <= '0;
        end else begin
            if (nextTake) nextFull <= 1'b0;
            case (state)
                F_IDLE: begin
                    if (frameStart) begin
                        addr   <= START21;
                        re     <= 1'b1;
                        rdaddr <= START20;
                        state  <= F_TOP;
                    end
                end
                F_TOP: begin
                    re     <= 1'b1;
                    rdaddr <= botAddr;
                    state  <= F_BOT;
                end
                F_BOT: begin
                    nextTop <= inData;
                    re      <= 1'b0;
                    state   <= F_CAP;
                end
                F_CAP: begin
                    nextBot  <= inData;
                    nextFull <= 1'b1;
                    addr     <= advAddr;
                    state    <= F_WAIT;
                end
                F_WAIT: begin
                    // A buffer being drained this cycle counts as free, so the stream never bubbles.
                    if (addr >= END21) begin
                        state <= F_IDLE;
                    end else if (!nextFull || nextTake) begin
                        re     <= 1'b1;
                        rdaddr <= addr[19:0];
                        state  <= F_TOP;
                    end
                end
                default: state <= F_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sobel_in_block.sv
// SRAM pixel reader: unpacks prefetched top/bottom word pairs into four 4-byte beats on a valid/ready stream.
module sobel_in_block #(
    parameter int unsigned STARTADDRESS = 0,
    parameter int unsigned ENDADDRESS   = 65536,
    parameter int unsigned ROWSTRIDE    = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [63:0]      inData,
    output logic             re,
    output logic [19:0]      rdaddr,
    output logic             busy,
    output logic             done,
    sobel_in_block_if.master stream
);
    import sobel_pkg::*;

    logic        nextFull;
    logic        nextTake;
    logic        fetchIdle;
    logic        frameStart;
    logic        xfer;
    logic        lastBeat;
    logic        curFull;
    logic [1:0]  beat;
    logic [63:0] nextTop;
    logic [63:0] nextBot;
    logic [63:0] curTop;
    logic [63:0] curBot;
    logic [15:0] topLane;
    logic [15:0] botLane;

    assign frameStart = start && !busy;
    assign xfer       = curFull && stream.outReady;
    assign lastBeat   = xfer && (beat == 2'd3);
    assign nextTake   = nextFull && (!curFull || lastBeat);

    sram_pair_fetch #(
        .STARTADDRESS(STARTADDRESS),
        .ENDADDRESS  (ENDADDRESS),
        .ROWSTRIDE   (ROWSTRIDE)
    ) fetch (
        .clk       (clk),
        .reset     (reset),
        .frameStart(frameStart),
        .nextTake  (nextTake),
        .inData    (inData),
        .re        (re),
        .rdaddr    (rdaddr),
        .nextFull  (nextFull),
        .nextTop   (nextTop),
        .nextBot   (nextBot),
        .fetchIdle (fetchIdle)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            curTop  <= '0;
            curBot  <= '0;
            curFull <= 1'b0;
            beat    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            if (xfer) beat <= beat + 2'd1;
            if (nextTake) begin
                curTop  <= nextTop;
                curBot  <= nextBot;
                curFull <= 1'b1;
            end else if (lastBeat) begin
                curFull <= 1'b0;
            end
            // The fetch has already gone idle by the time the final pair's last beat leaves.
            done <= lastBeat && !nextFull && fetchIdle;
            if (frameStart) busy <= 1'b1;
            else if (done)  busy <= 1'b0;
        end
    end

    assign topLane = laneWord(curTop, beat);
    assign botLane = laneWord(curBot, beat);

    assign stream.normalisedByte1 = botLane[15:8];
    assign stream.normalisedByte2 = botLane[7:0];
    assign stream.normalisedByte3 = topLane[15:8];
    assign stream.normalisedByte4 = topLane[7:0];
    assign stream.outValid        = curFull;

endmodule

// File: tb/tb_sobel_in_block.sv
// Self-checking bench for sobel_in_block: fixed single-pair vectors plus randomised multi-pair frames against a model.
module tb_sobel_in_block;
    import sobel_pkg::*;

    localparam int M_START = 252;
    localparam int M_END   = 572;

    typedef struct {
        logic [63:0]      top;
        logic [63:0]      bot;
        logic [3:0][31:0] exp;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        startS, startM;
    logic [63:0] inDataS, inDataM;
    logic        reS, reM;
    logic [19:0] rdaddrS, rdaddrM;
    logic        busyS, busyM;
    logic        doneS, doneM;
    logic [63:0] mem [0:1023];

    int errors = 0;
    int checks = 0;

    logic [31:0] gotBeats[$];
    logic [19:0] gotReads[$];
    logic [31:0] expBeats[$];
    logic [19:0] expReads[$];
    int          doneCount;
    int          bubbles;
    int          expBeatCount;
    logic        prevStall;
    logic [31:0] prevData;

    sobel_in_block_if ifS ();
    sobel_in_block_if ifM ();

    sobel_in_block #(.STARTADDRESS(0), .ENDADDRESS(1), .ROWSTRIDE(256)) dutS (
        .clk(clk), .reset(reset), .start(startS), .inData(inDataS), .re(reS),
        .rdaddr(rdaddrS), .busy(busyS), .done(doneS), .stream(ifS)
    );

    sobel_in_block #(.STARTADDRESS(M_START), .ENDADDRESS(M_END), .ROWSTRIDE(256)) dutM (
        .clk(clk), .reset(reset), .start(startM), .inData(inDataM), .re(reM),
        .rdaddr(rdaddrM), .busy(busyM), .done(doneM), .stream(ifM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM with one cycle of read latency; junk when no read was issued.
    always @(posedge clk) begin
        inDataS <= reS ? mem[rdaddrS[9:0]] : 64'hBAD0_BAD0_BAD0_BAD0;
        inDataM <= reM ? mem[rdaddrM[9:0]] : 64'hBAD0_BAD0_BAD0_BAD0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] bytesM();
        return {ifM.normalisedByte1, ifM.normalisedByte2, ifM.normalisedByte3, ifM.normalisedByte4};
    endfunction

    function automatic logic [31:0] bytesS();
        return {ifS.normalisedByte1, ifS.normalisedByte2, ifS.normalisedByte3, ifS.normalisedByte4};
    endfunction

    // Stream monitor for dutM: records transfers/reads/done and checks stall stability.
    always @(negedge clk) begin
        if (reset) begin
            prevStall <= 1'b0;
        end else begin
            if (prevStall) begin
                check("stall valid held", ifM.outValid, 1);
                check("stall data held", bytesM(), prevData);
            end
            if (gotBeats.size() > 0 && gotBeats.size() < expBeatCount && !ifM.outValid) bubbles++;
            if (ifM.outValid && ifM.outReady) gotBeats.push_back(bytesM());
            if (reM) gotReads.push_back(rdaddrM);
            if (doneM) doneCount++;
            prevStall <= ifM.outValid && !ifM.outReady;
            prevData  <= bytesM();
        end
    end

    // Reference: even rows (relative to the start row) are top rows; each top word pairs with the word one row below.
    task automatic buildModel();
        logic [63:0] tw, bw;
        int sh;
        expBeats.delete();
        expReads.delete();
        for (int a = M_START; a < M_END; a++) begin
            if ((((a >> 8) - (M_START >> 8)) % 2) != 0) continue;
            tw = mem[a];
            bw = mem[a + int'(ROWSTRIDE)];
            expReads.push_back(20'(a));
            expReads.push_back(20'(a + int'(ROWSTRIDE)));
            for (int k = 0; k < 4; k++) begin
                sh = 48 - 16 * k;
                expBeats.push_back({8'(bw >> (sh + 8)), 8'(bw >> sh), 8'(tw >> (sh + 8)), 8'(tw >> sh)});
            end
        end
        expBeatCount = expBeats.size();
    endtask

    task automatic compareRun(input string tag, input bit checkBubbles);
        int n;
        check($sformatf("%s beat count", tag), gotBeats.size(), expBeats.size());
        n = (gotBeats.size() < expBeats.size()) ? gotBeats.size() : expBeats.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s beat %0d", tag, i), gotBeats[i], expBeats[i]);
        check($sformatf("%s read count", tag), gotReads.size(), expReads.size());
        n = (gotReads.size() < expReads.size()) ? gotReads.size() : expReads.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s read %0d", tag, i), gotReads[i], expReads[i]);
        check($sformatf("%s done pulses", tag), doneCount, 1);
        if (checkBubbles) check($sformatf("%s stream bubbles", tag), bubbles, 0);
    endtask

    // mode 0: ready always high; 1: ready pattern 1,0,0,1; 2: random ready.
    task automatic runFrame(input string tag, input int mode, input bit pokeStart);
        int  cyc;
        bit  seen;
        gotBeats.delete();
        gotReads.delete();
        doneCount = 0;
        bubbles   = 0;
        buildModel();
        ifM.outReady = 1'b1;
        startM = 1'b1;
        tick();
        startM = 1'b0;
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 5000) begin
            case (mode)
                0:       ifM.outReady = 1'b1;
                1:       ifM.outReady = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: ifM.outReady = 1'($urandom_range(0, 1));
            endcase
            startM = pokeStart && (cyc == 7 || cyc == 60 || cyc == 200);
            tick();
            cyc++;
            if (doneM) seen = 1;
        end
        check($sformatf("%s done seen", tag), seen, 1);
        ifM.outReady = 1'b1;
        startM = pokeStart;
        tick();
        startM = 1'b0;
        check($sformatf("%s busy after done", tag), busyM, 0);
        check($sformatf("%s re after done", tag), reM, 0);
        repeat (4) tick();
        check($sformatf("%s idle re", tag), reM, 0);
        check($sformatf("%s idle valid", tag), ifM.outValid, 0);
        compareRun(tag, mode == 0);
    endtask

    initial begin
        vec_t vecs[2];
        int   cyc;

        vecs[0].top = 64'h0011223344556677;
        vecs[0].bot = 64'h8899AABBCCDDEEFF;
        vecs[0].exp[0] = 32'h88990011;
        vecs[0].exp[1] = 32'hAABB2233;
        vecs[0].exp[2] = 32'hCCDD4455;
        vecs[0].exp[3] = 32'hEEFF6677;
        vecs[1].top = 64'hFEDCBA9876543210;
        vecs[1].bot = 64'h0123456789ABCDEF;
        vecs[1].exp[0] = 32'h0123FEDC;
        vecs[1].exp[1] = 32'h4567BA98;
        vecs[1].exp[2] = 32'h89AB7654;
        vecs[1].exp[3] = 32'hCDEF3210;

        for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
        reset = 1'b1;
        startS = 1'b0;
        startM = 1'b0;
        ifS.outReady = 1'b1;
        ifM.outReady = 1'b1;
        expBeatCount = 0;
        repeat (3) tick();

        check("reset re", reS, 0);
        check("reset rdaddr", rdaddrS, 0);
        check("reset bytes", bytesS(), 0);
        check("reset valid", ifS.outValid, 0);
        check("reset busy", busyS, 0);
        check("reset done", doneS, 0);
        reset = 1'b0;
        tick();

        // Single-pair frames: latency, lane mapping, done/busy timing.
        for (int v = 0; v < 2; v++) begin
            mem[0]   = vecs[v].top;
            mem[256] = vecs[v].bot;
            startS = 1'b1;
            tick();
            startS = 1'b0;
            check("t+1 busy", busyS, 1);
            check("t+1 re", reS, 1);
            check("t+1 rdaddr", rdaddrS, 0);
            tick();
            check("t+2 re", reS, 1);
            check("t+2 rdaddr", rdaddrS, 256);
            tick();
            tick();
            check("t+4 valid", ifS.outValid, 0);
            tick();
            for (int k = 0; k < 4; k++) begin
                check($sformatf("vec%0d beat%0d valid", v, k), ifS.outValid, 1);
                check($sformatf("vec%0d beat%0d bytes", v, k), bytesS(), vecs[v].exp[k]);
                tick();
            end
            check("single done pulse", doneS, 1);
            check("single valid after", ifS.outValid, 0);
            tick();
            check("single done cleared", doneS, 0);
            check("single busy dropped", busyS, 0);
            tick();
        end

        runFrame("continuous", 0, 0);
        runFrame("backpressure", 1, 0);
        runFrame("random ready", 2, 0);
        runFrame("start while busy", 2, 1);

        // Abort on beat 2 of the second pair, then replay from the start address.
        buildModel();
        gotBeats.delete();
        gotReads.delete();
        ifM.outReady = 1'b1;
        startM = 1'b1;
        tick();
        startM = 1'b0;
        cyc = 0;
        while (gotBeats.size() < 6 && cyc < 100) begin
            tick();
            cyc++;
        end
        check("abort reached beat 6", gotBeats.size(), 6);
        check("abort beat 6 data", bytesM(), expBeats[6]);
        reset = 1'b1;
        tick();
        check("abort re", reM, 0);
        check("abort rdaddr", rdaddrM, 0);
        check("abort bytes", bytesM(), 0);
        check("abort valid", ifM.outValid, 0);
        check("abort busy", busyM, 0);
        check("abort done", doneM, 0);
        reset = 1'b0;
        gotBeats.delete();
        gotReads.delete();
        repeat (8) tick();
        check("abort no reads", gotReads.size(), 0);
        check("abort no beats", gotBeats.size(), 0);
        runFrame("replay", 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sobel_in_block.md
# sobel_in_block

- Read-side counterpart to the SRAM pixel writer.
- Fetches 64-bit word pairs from SRAM: a top-row word at address A and the bottom-row word at A+256.
- Unpacks each pair into four beats of four normalised bytes, in exactly the lane mapping the writer packed them.
- Streams the beats to downstream Sobel/particle stages over a valid/ready handshake.
- A one-pair prefetch buffer hides SRAM read latency, so a non-stalled stream never bubbles.

## Interface
Parameters:
- STARTADDRESS, 0, first top-row word address.
- ENDADDRESS, 65536, exclusive end; the fetch stops once the next top address is >= ENDADDRESS (compare at 21 bits).
- ROWSTRIDE, 256, word offset from the top row to the bottom row.

Ports:
- clk  in  1  single clock; all logic on the posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins a frame read; ignored while busy.
- inData  in  64  SRAM read data; valid exactly 1 cycle after rdaddr/re.
- re  out  1  SRAM read enable.
- rdaddr  out  20  SRAM read address.
- normalisedByte1..normalisedByte4  out  8 each  unpacked pixels.
- outValid  out  1  bytes valid this cycle.
- outReady  in  1  downstream accepts; a beat transfers when outValid && outReady.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the last beat transfers.

## Operation
- Lane mapping, beat k = 0..3, bit base b = 48 - 16k:
  - normalisedByte3 = top[b+15:b+8], normalisedByte4 = top[b+7:b].
  - normalisedByte1 = bot[b+15:b+8], normalisedByte2 = bot[b+7:b].
- Fetch FSM states:
  - F_IDLE: on start, load addr=STARTADDRESS and go to F_TOP.
  - F_TOP: re=1, rdaddr=addr.
  - F_BOT: re=1, rdaddr=addr+ROWSTRIDE; capture inData as the next top word.
  - F_CAP: re=0; capture inData as the next bottom word; set nextFull=1; advance addr.
  - F_WAIT: go to F_TOP when !nextFull and addr<ENDADDRESS; go to F_IDLE when addr>=ENDADDRESS.
- Address advance: if addr[7:0]==255 then addr+=257, else addr+=1. This skips the bottom row already read.
- Stream side holds a current pair (curFull) and a beat counter 0..3.
  - outValid=curFull.
  - On a transfer with beat 0..2: beat increments.
  - On a transfer with beat 3: beat resets to 0; the next pair is loaded into current if nextFull (nextFull cleared), else curFull=0.
  - When curFull=0 and nextFull=1: load current from next.
- The buffer never overwrites: F_CAP is only entered from a fetch started with nextFull=0.
  - A beat-3 transfer cannot coincide with F_CAP setting nextFull, because next was empty at fetch start.
  - When nextFull is cleared by the stream and set by F_CAP in the same cycle, the set wins.
- done pulses the cycle after the final beat transfers (fetch idle and addr>=ENDADDRESS, current and next empty). busy then drops.
- start while busy is ignored. A start in the same cycle as done is ignored.

## Timing
- Reset values, effective the cycle after reset is high:
  - re=0, rdaddr=0, bytes=0, outValid=0, busy=0, done=0.
  - FSM in F_IDLE, beat=0, curFull=0, nextFull=0.
- Reset mid-frame aborts at once; no further reads or beats.
- start at cycle t:
  - busy=1 at t+1.
  - F_TOP with rdaddr=STARTADDRESS at t+1.
  - rdaddr=STARTADDRESS+256 at t+2.
  - nextFull at t+4.
  - outValid=1 at t+5.
- Fetch takes 3 cycles per pair plus 1 cycle of F_WAIT recognition. Streaming takes at least 4 cycles per pair. With outReady held high, outValid stays continuously 1 after the first beat.
- outValid and data are held stable while outValid && !outReady.

## Structure
- Shared package sobel_pkg:
  - fetch state encodings F_IDLE..F_WAIT (3 bits).
  - ROWSTRIDE=256 and ROWWORDS=256 constants.
  - LANE width 8.
- Natural sub-module: sram_pair_fetch. It owns the fetch FSM, address advance, re/rdaddr and the next buffer, and outputs nextFull/nextTop/nextBot.
- The top level holds the current pair, the beat counter, the handshake and done.

## Test plan
- Single pair (STARTADDRESS=0, ENDADDRESS=1), top=64'h0011223344556677, bot=64'h8899AABBCCDDEEFF, outReady=1 -> beats (B1,B2,B3,B4) = (88,99,00,11), (AA,BB,22,33), (CC,DD,44,55), (EE,FF,66,77); then done.
- Row wrap from addr 254 -> reads issue at 254/510, 255/511, then 512/768.
- Backpressure: outReady toggled 1,0,0,1 on every beat -> no data change while stalled; no lost or duplicated beats over 3 pairs.
- Continuous stream of 64 pairs with outReady=1 -> outValid never deasserts between the first and last beat; exactly 256 beats, then one done pulse.
- Reset asserted on beat 2 of the second pair -> next cycle all outputs 0 and FSM idle; a fresh start replays from STARTADDRESS.
- start pulsed while busy -> ignored; address sequence unchanged.
